// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- inter-stage pipeline buffer (IF/ID, ID/EX, ...)
//
// This buffer carries an instruction word and its PC between CPU stages. It
// uses a valid/ready handshake, a hazard stall and a flush. It also keeps a
// saturating count of the valid entries that flushes have squashed.
// With SKID=1 it holds up to two entries (head + skid) and ready_o is registered.
// With SKID=0 it is a single register and ready_o is combinational.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   valid_i/ready_o         upstream handshake; inst_i, pc_i upstream payload
//   flush_i                 squash everything held (and this cycle's input)
//   stall_i                 freeze the head, block drain, still accept if space
//   valid_o/ready_i         downstream handshake; inst_o, pc_o head payload
//   occ_o                   entries held (0..2)
//   drop_cnt_o              valid entries discarded by flush, saturating
module pipe_stage_buf #(
  parameter int               INST_W   = 32,
  parameter int               PC_W     = 32,
  parameter bit               SKID     = 1'b1,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int               CNT_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  // The state encoding equals the occupancy, so occ_o is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  state_t              r_st,    w_st_nxt;
  logic [INST_W-1:0]   r_hinst, w_hinst_nxt;
  logic [PC_W-1:0]     r_hpc,   w_hpc_nxt;
  logic [INST_W-1:0]   r_sinst, w_sinst_nxt;
  logic [PC_W-1:0]     r_spc,   w_spc_nxt;
  logic [CNT_W-1:0]    r_drop,  w_drop_nxt;
  logic [CNT_W:0]      w_drop_sum;
  logic                w_acc, w_drn;

  assign valid_o    = (r_st != ST_EMPTY);
  assign inst_o     = r_hinst;
  assign pc_o       = r_hpc;
  assign occ_o      = r_st;
  assign drop_cnt_o = r_drop;

  assign w_drn = valid_o & ready_i & ~stall_i;
  assign w_acc = valid_i & ready_o;

  // Extra bit on the sum so saturation is a plain compare.
  assign w_drop_sum = {1'b0, r_drop} + {{(CNT_W-1){1'b0}}, r_st};

  always_comb begin
    w_st_nxt    = r_st;
    w_hinst_nxt = r_hinst;
    w_hpc_nxt   = r_hpc;
    w_sinst_nxt = r_sinst;
    w_spc_nxt   = r_spc;
    w_drop_nxt  = r_drop;
    if (flush_i) begin
      // The input is dropped even when it was accepted this cycle.
      w_st_nxt    = ST_EMPTY;
      w_hinst_nxt = NOP_INST;
      w_hpc_nxt   = '0;
      w_sinst_nxt = NOP_INST;
      w_spc_nxt   = '0;
      w_drop_nxt  = (w_drop_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : w_drop_sum[CNT_W-1:0];
    end else begin
      unique case (r_st)
        ST_EMPTY: begin
          if (w_acc) begin
            w_st_nxt    = ST_FULL;
            w_hinst_nxt = inst_i;
            w_hpc_nxt   = pc_i;
          end
        end
        ST_FULL: begin
          if (w_acc && w_drn) begin
            w_hinst_nxt = inst_i;
            w_hpc_nxt   = pc_i;
          end else if (w_acc) begin
            // Only reachable with SKID=1: when SKID=0, ready_o is low while full and not draining.
            w_st_nxt    = ST_SKID;
            w_sinst_nxt = inst_i;
            w_spc_nxt   = pc_i;
          end else if (w_drn) begin
            w_st_nxt    = ST_EMPTY;
            w_hinst_nxt = NOP_INST;
            w_hpc_nxt   = '0;
          end
        end
        ST_SKID: begin
          if (w_drn) begin
            w_st_nxt    = ST_FULL;
            w_hinst_nxt = r_sinst;
            w_hpc_nxt   = r_spc;
            w_sinst_nxt = NOP_INST;
            w_spc_nxt   = '0;
          end
        end
        default: w_st_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_st    <= ST_EMPTY;
      r_hinst <= NOP_INST;
      r_hpc   <= '0;
      r_sinst <= NOP_INST;
      r_spc   <= '0;
      r_drop  <= '0;
    end else begin
      r_st    <= w_st_nxt;
      r_hinst <= w_hinst_nxt;
      r_hpc   <= w_hpc_nxt;
      r_sinst <= w_sinst_nxt;
      r_spc   <= w_spc_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  generate
    if (SKID) begin : g_skid
      // Registered ready: look ahead at the next state so that ready_o never depends on ready_i.
      logic r_rdy;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_rdy <= 1'b1;
        else          r_rdy <= (w_st_nxt != ST_SKID);
      end
      assign ready_o = r_rdy;
    end else begin : g_reg
      assign ready_o = ~valid_o | w_drn;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf. It drives two instances from the same stimulus:
// u_skd (SKID=1, CNT_W=2, NOP=0) and u_reg (SKID=0, CNT_W=8, NOP=0x13).
// Each instance is compared every cycle against a queue-based model of the
// buffer's contents.
module tb_pipe_stage_buf;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i, flush_i, stall_i, ready_i;
  logic [31:0] inst_i, pc_i;

  logic [1:0]  rdy, vo;
  logic [31:0] inst_o [2];
  logic [31:0] pc_o   [2];
  logic [1:0]  occ    [2];
  logic [1:0]  drop0;
  logic [7:0]  drop1;

  always #5 clk_i = ~clk_i;

  pipe_stage_buf #(.INST_W(32), .PC_W(32), .SKID(1'b1), .NOP_INST(32'h0), .CNT_W(2)) u_skd (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(rdy[0]),
    .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i), .stall_i(stall_i),
    .valid_o(vo[0]), .ready_i(ready_i), .inst_o(inst_o[0]), .pc_o(pc_o[0]),
    .occ_o(occ[0]), .drop_cnt_o(drop0));

  pipe_stage_buf #(.INST_W(32), .PC_W(32), .SKID(1'b0), .NOP_INST(32'h13), .CNT_W(8)) u_reg (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(rdy[1]),
    .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i), .stall_i(stall_i),
    .valid_o(vo[1]), .ready_i(ready_i), .inst_o(inst_o[1]), .pc_o(pc_o[1]),
    .occ_o(occ[1]), .drop_cnt_o(drop1));

  // Reference model: one FIFO of held entries per instance.
  ent_t        mq [2][$];
  int          mdrop [2];
  bit          mrdy  [2];
  bit          macc  [2];
  bit          mdrn  [2];
  int          checks = 0, failures = 0;
  const int    SKP  [2] = '{1, 0};
  const int    CMAX [2] = '{3, 255};
  const logic [31:0] NOP [2] = '{32'h0, 32'h13};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_ready(int k);
    if (SKP[k] != 0) return mrdy[k];
    return (mq[k].size() == 0) || (ready_i && !stall_i);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mdrop[k] = 0;
      mrdy[k]  = 1'b1;
    end
  endtask

  task automatic check_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s[%0d].valid", tag, k), {63'd0, vo[k]}, {63'd0, mq[k].size() > 0});
      chk($sformatf("%s[%0d].inst", tag, k), {32'd0, inst_o[k]},
          {32'd0, (mq[k].size() > 0) ? mq[k][0].inst : NOP[k]});
      chk($sformatf("%s[%0d].pc", tag, k), {32'd0, pc_o[k]},
          {32'd0, (mq[k].size() > 0) ? mq[k][0].pc : 32'd0});
      chk($sformatf("%s[%0d].occ", tag, k), {62'd0, occ[k]}, 64'(mq[k].size()));
      chk($sformatf("%s[%0d].drop", tag, k), (k == 0) ? {62'd0, drop0} : {56'd0, drop1},
          64'(mdrop[k]));
    end
  endtask

  // One clock: check ready before the edge, advance the model, check after.
  task automatic cycle(input string tag);
    ent_t e;
    bit   fl;
    #1;
    e  = '{inst: inst_i, pc: pc_i};
    fl = flush_i;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s[%0d].ready", tag, k), {63'd0, rdy[k]}, {63'd0, exp_ready(k)});
      macc[k] = valid_i && exp_ready(k);
      mdrn[k] = (mq[k].size() > 0) && ready_i && !stall_i;
    end
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (fl) begin
        mdrop[k] = (mdrop[k] + mq[k].size() > CMAX[k]) ? CMAX[k] : mdrop[k] + mq[k].size();
        mq[k].delete();
      end else begin
        if (mdrn[k]) void'(mq[k].pop_front());
        if (macc[k]) mq[k].push_back(e);
      end
      if (SKP[k] != 0) mrdy[k] = fl ? 1'b1 : (mq[k].size() < 2);
    end
    check_outs(tag);
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit rd, input bit st, input bit fl);
    valid_i = v;
    pc_i    = pc;
    inst_i  = 32'hA500_0000 ^ pc;
    ready_i = rd;
    stall_i = st;
    flush_i = fl;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    rst_n_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_outs("reset");
    chk("reset.ready0", {63'd0, rdy[0]}, 64'd1);
    rst_n_i = 1'b1;

    // T2 streaming
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'(i * 4), 1, 0, 0);
      cycle("stream");
    end
    drive(0, 0, 1, 0, 0); cycle("stream_drain");
    cycle("stream_drain2");

    // T3 backpressure
    drive(1, 32'h10, 0, 0, 0); cycle("bp_fill");
    drive(1, 32'h14, 0, 0, 0); cycle("bp_skid");
    chk("bp.occ2", {62'd0, occ[0]}, 64'd2);
    chk("bp.rdy0", {63'd0, rdy[0]}, 64'd0);
    drive(0, 0, 1, 0, 0); cycle("bp_out1");
    chk("bp.pc14", {32'd0, pc_o[0]}, 64'h14);
    cycle("bp_out2");

    // T4 stall
    drive(1, 32'h20, 0, 0, 0); cycle("st_load");
    drive(0, 0, 1, 1, 0);
    repeat (3) cycle("st_hold");
    chk("st.pc20", {32'd0, pc_o[0]}, 64'h20);
    drive(0, 0, 1, 0, 0); cycle("st_rel");

    // T5 flush with occ=2 and incoming valid
    drive(1, 32'h30, 0, 0, 0); cycle("fl_a");
    drive(1, 32'h34, 0, 0, 0); cycle("fl_b");
    drive(1, 32'h38, 1, 0, 1); cycle("fl_go");
    drive(0, 0, 1, 0, 0); cycle("fl_after");

    // T1 async reset mid-traffic with occ=2, no clock edge
    drive(1, 32'h40, 0, 0, 0); cycle("rs_a");
    drive(1, 32'h44, 0, 0, 0); cycle("rs_b");
    #3 rst_n_i = 1'b0;
    #1;
    model_reset();
    chk("rst_async.valid", {63'd0, vo[0]}, 64'd0);
    chk("rst_async.ready", {63'd0, rdy[0]}, 64'd1);
    chk("rst_async.inst", {32'd0, inst_o[0]}, 64'd0);
    chk("rst_async.inst1", {32'd0, inst_o[1]}, 64'h13);
    @(posedge clk_i); #1;
    check_outs("rst_hold");
    rst_n_i = 1'b1;

    // T6 saturation: four flushes of occ=1 on the 2-bit counter
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(32'h100 + i * 4), 0, 0, 0); cycle("sat_fill");
      drive(0, 0, 0, 0, 1); cycle("sat_flush");
      chk("sat.drop", {62'd0, drop0}, 64'((i < 3) ? i + 1 : 3));
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
